// File: rtl/sdram_tester_pkg.sv
// Shared FSM states, pattern-mode codes and the pattern generator for the SDRAM tester.
// The pattern function works at a fixed maximum width; callers truncate to their data width.
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CTRL,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FINISH
  } state_e;

  localparam logic [1:0] PAT_FIXED   = 2'd0;
  localparam logic [1:0] PAT_INC     = 2'd1;
  localparam logic [1:0] PAT_WALK    = 2'd2;
  localparam logic [1:0] PAT_INV_INC = 2'd3;

  localparam int PAT_MAX_W = 64;

  function automatic logic [PAT_MAX_W-1:0] pattern_word(
    input logic [PAT_MAX_W-1:0] seed,
    input logic [31:0]          index,
    input logic [1:0]           mode,
    input int unsigned          width
  );
    logic [PAT_MAX_W-1:0] sum;
    sum = seed + PAT_MAX_W'(index);
    case (mode)
      PAT_FIXED: pattern_word = seed;
      PAT_INC:   pattern_word = sum;
      PAT_WALK:  pattern_word = PAT_MAX_W'(1) << (index % width);
      default:   pattern_word = ~sum;
    endcase
  endfunction

endpackage

// File: rtl/sdram_tester_watchdog.sv
// Per-phase cycle counter: expires after TIMEOUT_CYCLES cycles without a clear.
// Holds the expired value until cleared.
module sdram_tester_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (!expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// Write-then-readback BIST master for the SoC port of sdram_controller.
// Each request is held until busy is sampled high; a watchdog aborts any stuck phase.
module sdram_pattern_tester #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset_port,
  input  logic                    start_port,
  input  logic [ADDR_WIDTH-1:0]   base_addr_port,
  input  logic [COUNT_WIDTH-1:0]  word_count_port,
  input  logic [1:0]              pattern_mode_port,
  input  logic [DATA_WIDTH-1:0]   seed_port,
  output logic                    running_port,
  output logic                    done_port,
  output logic                    pass_port,
  output logic                    timeout_port,
  output logic [COUNT_WIDTH-1:0]  error_count_port,
  output logic [ADDR_WIDTH-1:0]   first_error_addr_port,
  output logic [ADDR_WIDTH-1:0]   soc_side_addr_port,
  output logic [DATA_WIDTH-1:0]   soc_side_wr_data_port,
  output logic [DATA_WIDTH/8-1:0] soc_side_wr_mask_port,
  output logic                    soc_side_wr_en_port,
  output logic                    soc_side_rd_en_port,
  input  logic                    soc_side_busy_port,
  input  logic                    soc_side_ready_port,
  input  logic [DATA_WIDTH-1:0]   soc_side_rd_data_port
);
  import sdram_tester_pkg::*;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] index_q, index_d, n_q, n_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d, first_q, first_d;
  logic [DATA_WIDTH-1:0]  seed_q, seed_d;
  logic [1:0]             mode_q, mode_d;
  logic timeout_q, timeout_d, pass_q, pass_d, done_q, done_d, running_q, running_d;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d, got_q, got_d;

  logic [DATA_WIDTH-1:0]  expected;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [COUNT_WIDTH-1:0] idx_inc;
  logic in_xfer, rd_phase, rd_sample, rd_miss, wd_clear, wd_expired;

  assign expected = DATA_WIDTH'(pattern_word(PAT_MAX_W'(seed_q), 32'(index_q), mode_q, DATA_WIDTH));
  assign cur_addr = base_q + ADDR_WIDTH'(index_q);
  assign idx_inc  = index_q + COUNT_WIDTH'(1);
  assign in_xfer  = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT) ||
                    (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
  assign rd_phase = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);

  // Only the first ready of a read is compared; a read that ends without any ready is a miss.
  assign rd_sample = rd_phase && soc_side_ready_port && !got_q;
  assign rd_miss   = (rd_sample && (soc_side_rd_data_port != expected)) ||
                     ((state_q == ST_RD_WAIT) && !soc_side_busy_port && !got_q && !soc_side_ready_port);
  assign wd_clear  = !in_xfer || (state_d != state_q);

  sdram_tester_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i     (clk),
    .rst_i     (reset_port),
    .clear_i   (wd_clear),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    base_d    = base_q;
    n_d       = n_q;
    mode_d    = mode_q;
    seed_d    = seed_q;
    err_d     = err_q;
    first_d   = first_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    running_d = running_q;
    got_d     = got_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;

    case (state_q)
      ST_IDLE: if (start_port) begin
        base_d    = base_addr_port;
        n_d       = word_count_port;
        mode_d    = pattern_mode_port;
        seed_d    = seed_port;
        err_d     = '0;
        first_d   = '0;
        timeout_d = 1'b0;
        pass_d    = 1'b0;
        running_d = 1'b1;
        state_d   = ST_WAIT_CTRL;
      end
      ST_WAIT_CTRL: if (!soc_side_busy_port) begin
        index_d = '0;
        state_d = (n_q == '0) ? ST_FINISH : ST_WR_REQ;
      end
      ST_WR_REQ: if (soc_side_busy_port) state_d = ST_WR_WAIT;
      ST_WR_WAIT: if (!soc_side_busy_port) begin
        if (idx_inc == n_q) begin
          index_d = '0;
          state_d = ST_RD_REQ;
        end else begin
          index_d = idx_inc;
          state_d = ST_WR_REQ;
        end
      end
      ST_RD_REQ: if (soc_side_busy_port) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (!soc_side_busy_port) begin
        index_d = idx_inc;
        state_d = (idx_inc == n_q) ? ST_FINISH : ST_RD_REQ;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (in_xfer && wd_expired) begin
      timeout_d = 1'b1;
      state_d   = ST_FINISH;
    end

    if (rd_sample) got_d = 1'b1;
    if ((state_d == ST_RD_REQ) && (state_q != ST_RD_REQ)) got_d = 1'b0;

    if (rd_miss) begin
      if (err_q != '1) err_d = err_q + COUNT_WIDTH'(1);
      if (err_q == '0) first_d = cur_addr;
    end

    if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) begin
      done_d    = 1'b1;
      running_d = 1'b0;
      pass_d    = (err_d == '0) && !timeout_d;
    end

    // Requests are registered from the next state so they drop with the REQ exit.
    wr_en_d = (state_d == ST_WR_REQ);
    rd_en_d = (state_d == ST_RD_REQ);
  end

  always_ff @(posedge clk or posedge reset_port) begin
    if (reset_port) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      base_q    <= '0;
      n_q       <= '0;
      mode_q    <= '0;
      seed_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      got_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      base_q    <= base_d;
      n_q       <= n_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      err_q     <= err_d;
      first_q   <= first_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      running_q <= running_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      got_q     <= got_d;
    end
  end

  assign running_port          = running_q;
  assign done_port             = done_q;
  assign pass_port             = pass_q;
  assign timeout_port          = timeout_q;
  assign error_count_port      = err_q;
  assign first_error_addr_port = first_q;
  assign soc_side_addr_port    = cur_addr;
  assign soc_side_wr_data_port = wr_en_q ? expected : '0;
  assign soc_side_wr_mask_port = {(DATA_WIDTH/8){wr_en_q}};
  assign soc_side_wr_en_port   = wr_en_q;
  assign soc_side_rd_en_port   = rd_en_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: behavioural controller model with memory, write/read
// scoreboards fed at start, a table of full tests and hand-written corner sequences.
module tb_sdram_pattern_tester;

  localparam int INIT_CYCLES = 500;
  localparam int TO_CYCLES   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [22:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [1:0]  pattern_mode = '0;
  logic [31:0] seed = '0;
  logic        running, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [22:0] first_err, s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_mask;
  logic        s_wr, s_rd;
  logic        busy, ready;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  sdram_pattern_tester #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .reset_port(rst), .start_port(start), .base_addr_port(base_addr),
    .word_count_port(word_count), .pattern_mode_port(pattern_mode), .seed_port(seed),
    .running_port(running), .done_port(done), .pass_port(pass), .timeout_port(timeout),
    .error_count_port(err_cnt), .first_error_addr_port(first_err),
    .soc_side_addr_port(s_addr), .soc_side_wr_data_port(s_wdata),
    .soc_side_wr_mask_port(s_mask), .soc_side_wr_en_port(s_wr), .soc_side_rd_en_port(s_rd),
    .soc_side_busy_port(busy), .soc_side_ready_port(ready), .soc_side_rd_data_port(rdata)
  );

  // Controller model knobs, driven by the test process.
  bit          c_en = 0, dbl_ready = 0, nr_en = 0;
  logic [22:0] c_lo = '0, c_hi = '0, nr_addr = '0;
  int          hang_wr = 0;
  logic [31:0] mem [logic [22:0]];

  int          init_cnt, cnt, wr_cnt;
  bit          pend_rd, hang, acc_wr, acc_rd;
  logic [22:0] rd_addr, acc_addr;
  logic [31:0] acc_data;
  logic [3:0]  acc_mask;

  function automatic logic [31:0] model_rd(input logic [22:0] a);
    logic [31:0] v;
    v = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    if (c_en && a >= c_lo && a <= c_hi) v = v ^ 32'h1;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= INIT_CYCLES; cnt <= 0; busy <= 1'b1; ready <= 1'b0; rdata <= '0;
      pend_rd <= 0; wr_cnt <= 0; hang <= 0; acc_wr <= 0; acc_rd <= 0;
      rd_addr <= '0; acc_addr <= '0; acc_data <= '0; acc_mask <= '0;
    end else begin
      ready  <= 1'b0;
      acc_wr <= 0;
      acc_rd <= 0;
      if (start) begin wr_cnt <= 0; hang <= 0; end
      if (init_cnt != 0) begin
        init_cnt <= init_cnt - 1;
        if (init_cnt == 1) busy <= 1'b0;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 2 && pend_rd && !(nr_en && rd_addr == nr_addr)) begin
          ready <= 1'b1; rdata <= model_rd(rd_addr);
        end
        if (cnt == 1) begin
          busy <= 1'b0;
          if (pend_rd && dbl_ready) begin ready <= 1'b1; rdata <= ~model_rd(rd_addr); end
        end
      end else if (s_wr && !hang) begin
        if (hang_wr != 0 && wr_cnt + 1 == hang_wr) hang <= 1;
        else begin
          wr_cnt <= wr_cnt + 1; busy <= 1'b1; cnt <= 3; pend_rd <= 0;
          acc_wr <= 1; acc_addr <= s_addr; acc_data <= s_wdata; acc_mask <= s_mask;
        end
      end else if (s_rd) begin
        busy <= 1'b1; cnt <= 3; pend_rd <= 1; rd_addr <= s_addr;
        acc_rd <= 1; acc_addr <= s_addr;
      end
    end
  end

  typedef struct packed { logic [22:0] addr; logic [31:0] data; } wr_t;
  wr_t         wq[$];
  logic [22:0] rq[$];

  int errors = 0, checks = 0, cyc = 0, wr_rise = 0, rd_acc = 0;
  bit req_seen = 0, prev_wr = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_pat(input logic [31:0] s, input int i, input logic [1:0] m);
    logic [31:0] inc;
    inc = s + 32'(i);
    case (m)
      2'd0:    return s;
      2'd1:    return inc;
      2'd2:    return 32'h1 << (i % 32);
      default: return ~inc;
    endcase
  endfunction

  task automatic tick();
    wr_t         e;
    logic [22:0] ea;
    @(negedge clk);
    cyc++;
    if (s_wr || s_rd) req_seen = 1;
    if (s_wr && !prev_wr) wr_rise = cyc;
    prev_wr = s_wr;
    if (acc_wr) begin
      mem[acc_addr] = acc_data;
      chk(wq.size() != 0, "sb_wr_unexpected", {41'd0, acc_addr}, 64'd0);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk({acc_addr, acc_data} == {e.addr, e.data}, "sb_wr_addr_data",
            {9'd0, acc_addr, acc_data}, {9'd0, e.addr, e.data});
        chk(acc_mask == 4'hF, "sb_wr_mask", {60'd0, acc_mask}, 64'hF);
      end
    end
    if (acc_rd) begin
      rd_acc++;
      chk(rq.size() != 0, "sb_rd_unexpected", {41'd0, acc_addr}, 64'd0);
      if (rq.size() != 0) begin
        ea = rq.pop_front();
        chk(acc_addr == ea, "sb_rd_addr", {41'd0, acc_addr}, {41'd0, ea});
      end
    end
  endtask

  task automatic start_test(input logic [22:0] b, input int n, input logic [1:0] m, input logic [31:0] s);
    logic [22:0] a;
    wq.delete();
    rq.delete();
    for (int i = 0; i < n; i++) begin
      a = b + 23'(i);
      wq.push_back('{addr: a, data: exp_pat(s, i, m)});
      rq.push_back(a);
    end
    base_addr = b; word_count = 16'(n); pattern_mode = m; seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = ~b; word_count = 16'hFFFF; pattern_mode = ~m; seed = ~s;
  endtask

  task automatic wait_done(input int limit, output bit seen, output int ticks);
    seen = 0;
    ticks = 0;
    while (!seen && ticks < limit) begin
      tick();
      ticks++;
      if (done) seen = 1;
    end
  endtask

  typedef struct {
    logic [22:0] base; int n; logic [1:0] mode; logic [31:0] seed;
    bit c_en; logic [22:0] c_lo; logic [22:0] c_hi;
    bit e_pass; int e_err; logic [22:0] e_first;
  } vec_t;

  vec_t vt[6];
  bit   seen, any_wr;
  int   tk, diff;

  initial begin
    vt[0] = '{23'd8086, 16, 2'd1, 32'hCCF0F0F1, 0, 23'd0, 23'd0, 1, 0, 23'd0};
    vt[1] = '{23'd8086, 16, 2'd1, 32'hCCF0F0F1, 1, 23'd8090, 23'd8090, 0, 1, 23'd8090};
    vt[2] = '{23'h7FFFFE, 4, 2'd2, 32'h0, 0, 23'd0, 23'd0, 1, 0, 23'd0};
    vt[3] = '{23'h1234, 5, 2'd0, 32'hA5A5A5A5, 1, 23'h1238, 23'h1238, 0, 1, 23'h1238};
    vt[4] = '{23'h40, 8, 2'd3, 32'hFFFFFFFE, 0, 23'd0, 23'd0, 1, 0, 23'd0};
    vt[5] = '{23'h300, 10, 2'd1, 32'h10, 1, 23'h303, 23'h306, 0, 4, 23'h303};

    #1;
    chk({running, done, pass, timeout} == 4'b0, "reset_flags", {60'd0, running, done, pass, timeout}, 64'd0);
    chk(err_cnt == 0 && first_err == 0, "reset_results", {25'd0, err_cnt, first_err}, 64'd0);
    chk({s_wr, s_rd, s_mask} == 6'b0, "reset_requests", {58'd0, s_wr, s_rd, s_mask}, 64'd0);
    chk(s_addr == 0 && s_wdata == 0, "reset_bus", {9'd0, s_addr, s_wdata}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      c_en = vt[v].c_en; c_lo = vt[v].c_lo; c_hi = vt[v].c_hi;
      start_test(vt[v].base, vt[v].n, vt[v].mode, vt[v].seed);
      chk(running == 1'b1, $sformatf("v%0d_running", v), {63'd0, running}, 64'd1);
      wait_done(3000, seen, tk);
      chk(seen, $sformatf("v%0d_done_seen", v), {63'd0, seen}, 64'd1);
      chk(pass == vt[v].e_pass, $sformatf("v%0d_pass", v), {63'd0, pass}, {63'd0, vt[v].e_pass});
      chk(err_cnt == 16'(vt[v].e_err), $sformatf("v%0d_errors", v), {48'd0, err_cnt}, 64'(vt[v].e_err));
      chk(first_err == vt[v].e_first, $sformatf("v%0d_first_addr", v), {41'd0, first_err}, {41'd0, vt[v].e_first});
      chk(!timeout && !running, $sformatf("v%0d_timeout_running", v), {62'd0, timeout, running}, 64'd0);
      tick();
      chk(!done && pass == vt[v].e_pass, $sformatf("v%0d_done_pulse_stable", v), {62'd0, done, pass}, {63'd0, vt[v].e_pass});
      chk(wq.size() == 0 && rq.size() == 0, $sformatf("v%0d_sb_drained", v), 64'(wq.size() + rq.size()), 64'd0);
      tick();
    end
    c_en = 0;

    // Zero-length test: no requests, done the cycle after the idle controller is seen.
    req_seen = 0;
    start_test(23'h55, 0, 2'd1, 32'h1);
    wait_done(50, seen, tk);
    chk(seen && tk == 1, "n0_done_latency", 64'(tk), 64'd1);
    chk(pass && err_cnt == 0, "n0_pass", {47'd0, pass, err_cnt}, {47'd1, 16'd0});
    tick(); tick();
    chk(!req_seen, "n0_no_requests", {63'd0, req_seen}, 64'd0);

    // Second, corrupted ready after the first must be ignored.
    dbl_ready = 1;
    start_test(23'h500, 4, 2'd1, 32'h7);
    wait_done(500, seen, tk);
    chk(seen && pass && err_cnt == 0, "dbl_ready_pass", {47'd0, pass, err_cnt}, {47'd1, 16'd0});
    dbl_ready = 0;
    tick();

    // A read with no ready at all counts as one mismatch.
    nr_en = 1; nr_addr = 23'h601;
    start_test(23'h600, 4, 2'd1, 32'h9);
    wait_done(500, seen, tk);
    chk(seen && !pass && err_cnt == 1, "no_ready_errors", {47'd0, pass, err_cnt}, {47'd0, 16'd1});
    chk(first_err == 23'h601, "no_ready_first_addr", {41'd0, first_err}, {41'd0, 23'h601});
    nr_en = 0;
    tick();

    // Controller never accepts the third write: watchdog must end the test.
    hang_wr = 3;
    start_test(23'h700, 8, 2'd1, 32'h3);
    wait_done(500, seen, tk);
    diff = cyc - wr_rise;
    chk(seen && diff >= TO_CYCLES - 1 && diff <= TO_CYCLES + 2, "timeout_latency", 64'(diff), 64'(TO_CYCLES));
    chk(timeout && !pass, "timeout_flags", {62'd0, timeout, pass}, 64'd2);
    any_wr = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (s_wr) any_wr = 1;
    end
    chk(!any_wr, "timeout_wr_low", {63'd0, any_wr}, 64'd0);
    hang_wr = 0;
    wq.delete();
    rq.delete();

    // Reset in the middle of the read phase, then a fresh inverted-incrementing test.
    c_en = 1; c_lo = 23'h800; c_hi = 23'h800;
    start_test(23'h800, 8, 2'd1, 32'h100);
    tk = rd_acc + 2;
    for (int k = 0; k < 1000 && rd_acc < tk; k++) tick();
    chk(rd_acc >= tk, "midreset_reached_reads", 64'(rd_acc), 64'(tk));
    tick();
    chk(err_cnt == 1 && running, "midreset_pre_state", {47'd0, running, err_cnt}, {47'd1, 16'd1});
    #2 rst = 1'b1;
    #1;
    chk({running, done, pass, timeout, s_wr, s_rd} == 6'b0, "midreset_flags",
        {58'd0, running, done, pass, timeout, s_wr, s_rd}, 64'd0);
    chk(err_cnt == 0 && first_err == 0, "midreset_results", {25'd0, err_cnt, first_err}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    c_en = 0;
    tick();
    start_test(23'h900, 8, 2'd3, 32'h12345678);
    wait_done(3000, seen, tk);
    chk(seen && pass && err_cnt == 0 && !timeout, "after_reset_pass",
        {46'd0, seen, pass, err_cnt}, {46'd0, 2'b11, 16'd0});
    chk(wq.size() == 0 && rq.size() == 0, "after_reset_sb_drained", 64'(wq.size() + rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sdram_pattern_tester.md
# sdram_pattern_tester

Self-checking traffic generator that drives the SoC side of `sdram_controller`. On a start pulse it writes a parametrised number of words from a base address using a selectable data pattern. It then reads every word back, compares each one, and reports pass/fail, error count, first failing address and timeout. It sits between board-level control (or a debug register block) and the controller, and serves as both bring-up BIST and regression stimulus.

## Interface
Parameters:
- `ADDR_WIDTH`, 23, word address width (matches controller `soc_side_addr_port`)
- `DATA_WIDTH`, 32, data word width; multiple of 8
- `COUNT_WIDTH`, 16, width of word count and error count
- `TIMEOUT_CYCLES`, 1024, watchdog limit per transaction phase

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `reset_port`  in  1  asynchronous, active-high reset
- `start_port`  in  1  one-cycle pulse; begins a test when idle
- `base_addr_port`  in  ADDR_WIDTH  first word address, sampled on start
- `word_count_port`  in  COUNT_WIDTH  number of words N, sampled on start
- `pattern_mode_port`  in  2  0 fixed, 1 incrementing, 2 walking-one, 3 inverted incrementing; sampled on start
- `seed_port`  in  DATA_WIDTH  pattern seed, sampled on start
- `running_port`  out  1  high from accepted start until done
- `done_port`  out  1  one-cycle pulse at test end
- `pass_port`  out  1  valid from done until next start
- `timeout_port`  out  1  watchdog fired during last test
- `error_count_port`  out  COUNT_WIDTH  mismatches in last test, saturating
- `first_error_addr_port`  out  ADDR_WIDTH  address of first mismatch
- `soc_side_addr_port`  out  ADDR_WIDTH  to controller
- `soc_side_wr_data_port`  out  DATA_WIDTH  to controller
- `soc_side_wr_mask_port`  out  DATA_WIDTH/8  all ones during writes, else zero
- `soc_side_wr_en_port`  out  1  write request
- `soc_side_rd_en_port`  out  1  read request
- `soc_side_busy_port`  in  1  controller executing a command or initialising
- `soc_side_ready_port`  in  1  controller read data valid this cycle
- `soc_side_rd_data_port`  in  DATA_WIDTH  controller read data

## Operation
- Reset values: all outputs 0. Registered internals also clear: state IDLE, index, error count.
- States:
  - IDLE: waits for start. On start, samples the inputs, clears results, sets running, and goes to WAIT_CTRL.
  - WAIT_CTRL: waits for `soc_side_busy_port`=0, which covers the controller's 200 µs init. Then index=0 and go to WR_REQ. If N=0, go directly to FINISH.
  - WR_REQ: drives addr/data/mask and holds `wr_en` until busy is sampled 1, then goes to WR_WAIT.
  - WR_WAIT: waits for busy=0. Then index++; if index==N, index=0 and go to RD_REQ, else go to WR_REQ.
  - RD_REQ: holds `rd_en` until busy is sampled 1, then goes to RD_WAIT.
  - RD_WAIT: on the ready cycle, compares rd_data to the expected pattern. Then waits for busy=0. Then index++; if index==N go to FINISH, else go to RD_REQ.
  - FINISH: pulses done for one cycle, drops running, and sets `pass` = (errors==0 && !timeout). Returns to IDLE.
- Address: base+index, modulo 2^ADDR_WIDTH (wrap-around allowed).
- Patterns, where i is the index:
  - Fixed: seed.
  - Incrementing: seed+i, modulo 2^DATA_WIDTH.
  - Walking-one: 1 << (i mod DATA_WIDTH).
  - Inverted incrementing: ~(seed+i).
- Mismatches: error count increments per mismatch and saturates at all-ones. `first_error_addr` is captured only on the first mismatch.
- Read-back behaviour:
  - Ready arriving more than once per read: only the first is compared.
  - Ready never arriving before busy falls: counted as one mismatch.
- Watchdog: counter resets on every state change. Reaching TIMEOUT_CYCLES in any of the four REQ/WAIT states sets `timeout`, deasserts requests and goes to FINISH. WAIT_CTRL is exempt.
- `start_port` is ignored while running.
- Reset mid-test: requests drop asynchronously, state returns to IDLE, results clear.

## Timing
- A request is asserted the cycle after entering its REQ state and is held for at least 1 cycle. It deasserts in the cycle after busy is sampled high.
- `done_port` is asserted exactly 1 cycle after the final read's busy fall (or after the timeout).
- Result outputs are stable from done until the next accepted start.
- Minimum test duration with an instant controller (busy 1 cycle, no init): 4N+3 cycles.

## Structure
- Package `sdram_tester_pkg`: state enum, pattern-mode constants, and the `pattern_word` function (seed, index, mode).
- One sub-module, `sdram_tester_watchdog`: a TIMEOUT_CYCLES counter with clear/expire.

## Test plan
- Controller model with memory, init busy 500 cycles; base=8086, N=16, mode 1, seed 0xCCF0F0F1 -> 16 writes then 16 reads; done, pass=1, errors=0.
- Same test, but the model corrupts bit 0 at address 8090 -> pass=0, errors=1, first_error_addr=8090.
- base=0x7FFFFE, N=4, mode 2 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001 with data 1, 2, 4, 8; pass=1.
- N=0 -> done 1 cycle after controller idle; pass=1; no wr_en/rd_en ever asserted.
- Model never raises busy on the 3rd write, TIMEOUT_CYCLES=64 -> timeout=1, pass=0, done within 66 cycles of the request, wr_en low afterwards.
- Assert reset_port during RD_WAIT, then start a new test -> outputs 0 immediately; the new test with mode 3, N=8 passes.
